sophon_ext_loader: RTL and testbench
====================================

# sophon_ext_loader

Hardware program loader that acts as the initiator on the core's external-access slave port (`ext_req`/`ext_we`/`ext_addr`/`ext_wdata` in; `ext_ack`/`ext_error`/`ext_rdata` out).
- Consumes a byte stream containing a header and a payload, and writes the payload word by word into ITCM/DTCM.
- Reads the region back and verifies an XOR checksum.
- Holds the core in soft reset until the region verifies, then releases `rst_soft_ni`.
- Replaces simulation backdoor preload in FPGA and silicon bring-up; sits between a UART/JTAG byte source and `SOPHON_TOP`.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1024: maximum cycles a request may wait for `ext_ack_i`.
- `CNT_W`, default 16: width of the word counter; sets the maximum image size (2^CNT_W − 1 words).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  single-cycle pulse that starts a load session.
- `s_valid_i`  in  1  stream byte valid.
- `s_data_i`  in  8  stream byte.
- `s_ready_o`  out  1  stream byte accepted when `s_valid_i & s_ready_o`.
- `ext_req_o`  out  1  bus request to core external-access port.
- `ext_we_o`  out  1  1 = write, 0 = read.
- `ext_addr_o`  out  32  byte address, word-aligned.
- `ext_wdata_o`  out  32  write data.
- `ext_ack_i`  in  1  transaction complete.
- `ext_error_i`  in  1  qualified by `ext_ack_i`; bus error.
- `ext_rdata_i`  in  32  read data, valid with `ext_ack_i` on reads.
- `rst_soft_no`  out  1  drives core `rst_soft_ni`; 0 holds the core.
- `busy_o`  out  1  session in progress.
- `done_o`  out  1  image loaded and verified; core released.
- `err_o`  out  1  session aborted.
- `err_code_o`  out  3  abort reason: 1 = bad header, 2 = bus error, 3 = timeout, 4 = checksum mismatch.
- `word_cnt_o`  out  CNT_W  words completed in the current pass.

## Operation
- Stream format, all fields little-endian:
  - 4 bytes `BASE`.
  - 4 bytes `LEN` in bytes.
  - `LEN` payload bytes. Byte k of each word maps to bits [8k+7:8k].
- States and transitions:
  - IDLE: `start_i` → HDR.
  - HDR: accepts 8 bytes.
    - If `BASE[1:0]!=0`, or `LEN[1:0]!=0`, or `LEN==0`, or `LEN>>2 > 2^CNT_W−1`: → ERR, code 1.
    - Otherwise: `words=LEN>>2`, `addr=BASE`, `csum=0` → DATA.
  - DATA: accepts 4 bytes, assembles a word, `csum ^= word` → WR.
  - WR: issues a write.
    - On ack without error: `addr+=4`, `word_cnt++`. If `word_cnt==words`: `addr=BASE`, `word_cnt=0`, `rsum=0` → RD. Otherwise → DATA.
  - RD: issues a read.
    - On ack without error: `rsum ^= ext_rdata_i`, `addr+=4`, `word_cnt++`. If last word → CHECK. Otherwise stay in RD.
  - CHECK: `rsum==csum` → RUN. Otherwise → ERR, code 4.
  - RUN: `rst_soft_no=1`, `done_o=1`.
  - ERR: `err_o=1`, `rst_soft_no=0`.
- Any ack with `ext_error_i=1` → ERR, code 2. Timeout → ERR, code 3.
- `start_i` in IDLE, RUN or ERR begins a new session: clears `done_o`, `err_o`, `err_code_o` and `word_cnt_o`, drives `rst_soft_no=0`, → HDR. `start_i` is ignored while `busy_o=1`.
- `busy_o=1` in HDR, DATA, WR, RD and CHECK.
- `ext_addr_o` is a 32-bit modulo increment; `0xFFFFFFFC+4` wraps to 0 with no error.

## Timing
- Reset values: `s_ready_o=0`, `ext_req_o=0`, `ext_we_o=0`, `ext_addr_o=0`, `ext_wdata_o=0`, `rst_soft_no=0`, `busy_o=0`, `done_o=0`, `err_o=0`, `err_code_o=0`, `word_cnt_o=0`; state IDLE.
- `s_ready_o` is registered; it is 1 only in HDR and DATA. It drops the cycle after the 4th payload byte of a word is accepted.
- `ext_req_o` rises the cycle after entry to WR or RD.
- `ext_req_o`, `ext_we_o`, `ext_addr_o` and `ext_wdata_o` are registered and held stable until the cycle `ext_ack_i=1`.
- `ext_req_o` is low for at least 1 cycle after each ack. Back-to-back reads therefore issue every 2 cycles plus ack latency.
- `ext_ack_i` while `ext_req_o=0` is ignored.
- Timeout counter:
  - Clears when a request is raised and increments while the request is outstanding.
  - Reaching `TIMEOUT_CYC` with no ack drops `ext_req_o` the next cycle → ERR, code 3.
  - An ack arriving in the same cycle the count reaches `TIMEOUT_CYC` wins; no timeout is raised.
- CHECK takes 1 cycle. `done_o` and `rst_soft_no` rise together, 2 cycles after the final read ack.
- `rst_n` asserted mid-session: all outputs return to their reset values immediately (asynchronously); any outstanding request is abandoned.

## Test plan
- **Normal load.** Header `BASE=0x80000000`, `LEN=8`; payload `11 22 33 44 55 66 77 88`; slave acks after 2 cycles → writes `0x44332211`@0x80000000 and `0x88776655`@0x80000004. Then two reads, then `done_o=1`, `rst_soft_no=1`, `word_cnt_o=2`.
- **Bad header.** `BASE=0x80000002` → `err_o=1`, `err_code_o=1`, no `ext_req_o` ever asserted. Repeat with `LEN=6`: same response.
- **Bus error.** `ext_error_i=1` with the ack of the 2nd write → `err_code_o=2`, `word_cnt_o=1`, `rst_soft_no=0`.
- **Timeout.** With `TIMEOUT_CYC=8`, the slave never acks → `ext_req_o` drops after 8 cycles, `err_code_o=3`. Also ack on exactly the 8th cycle → no error.
- **Checksum mismatch.** Slave returns `0xDEADBEEF` on the first read → `err_code_o=4`. A following `start_i` plus a valid image → `done_o=1`.
- **Stream throttling and reset.** Random `s_valid_i` gaps give the same result as the normal load. `rst_n` pulsed while in RD → all outputs at reset values; a new session succeeds.

Source files
------------

// File: rtl/sophon_ext_loader.sv
// Purpose: streams a program image into ITCM/DTCM over the core ext port, reads it back to verify an XOR checksum, then releases core soft reset.
// Latency: one bus transaction per word per pass (req 1 cycle after issue, dropped on ack); done_o/rst_soft_no rise 2 cycles after the final read ack.
// Backpressure: s_ready_o is registered and high only while collecting header/payload bytes; bus requests are held until ack or timeout.
module sophon_ext_loader #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             s_valid_i,
   input  logic [7:0]       s_data_i,
   output logic             s_ready_o,
   output logic             ext_req_o,
   output logic             ext_we_o,
   output logic [31:0]      ext_addr_o,
   output logic [31:0]      ext_wdata_o,
   input  logic             ext_ack_i,
   input  logic             ext_error_i,
   input  logic [31:0]      ext_rdata_i,
   output logic             rst_soft_no,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [2:0]       err_code_o,
   output logic [CNT_W-1:0] word_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_DATA, S_WR, S_RD, S_CHECK, S_RUN, S_ERR
   } state_t;

   localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
   // The request is visible for exactly TIMEOUT_CYC cycles; the last one is still allowed to ack.
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0]      MAX_WORDS = 32'((64'd1 << CNT_W) - 64'd1);

   localparam logic [2:0] CODE_HDR  = 3'd1;
   localparam logic [2:0] CODE_BUS  = 3'd2;
   localparam logic [2:0] CODE_TMO  = 3'd3;
   localparam logic [2:0] CODE_CSUM = 3'd4;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       w_code_nxt;

   logic             r_s_ready;
   logic [2:0]       r_hdr_cnt;
   logic [55:0]      r_hdr;
   logic [1:0]       r_byte_cnt;
   logic [31:0]      r_base;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [CNT_W-1:0] r_words;
   logic [CNT_W-1:0] r_word_cnt;
   logic [31:0]      r_csum;
   logic [31:0]      r_rsum;
   logic             r_req;
   logic             r_we;
   logic [TMO_W-1:0] r_tmo;
   logic             r_done;
   logic             r_err;
   logic [2:0]       r_err_code;
   logic             r_rst_soft;

   logic             w_hs;
   logic             w_start;
   logic [63:0]      w_hdr;
   logic             w_hdr_bad;
   logic [31:0]      w_word;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_last;
   logic             w_hdr_acc;
   logic             w_dat_acc;
   logic             w_issue;
   logic             w_ack_ok;
   logic             w_tmo_hit;

   assign w_hs      = s_valid_i & r_s_ready;
   assign w_start   = start_i & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERR));
   // Header bytes arrive BASE first, little-endian, so the newest byte is the top byte of LEN.
   assign w_hdr     = {s_data_i, r_hdr};
   assign w_hdr_bad = (w_hdr[1:0] != 2'b00) | (w_hdr[33:32] != 2'b00) | (w_hdr[63:32] == 32'd0)
                    | ({2'b00, w_hdr[63:34]} > MAX_WORDS);
   assign w_word    = {s_data_i, r_wdata[31:8]};
   assign w_cnt_inc = r_word_cnt + 1'b1;
   assign w_last    = (w_cnt_inc == r_words);

   // Next-state decode and the per-cycle control strobes used by the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = 3'd0;
      w_hdr_acc   = 1'b0;
      w_dat_acc   = 1'b0;
      w_issue     = 1'b0;
      w_ack_ok    = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         S_IDLE, S_RUN, S_ERR: begin
            if (start_i) w_state_nxt = S_HDR;
         end
         S_HDR: begin
            if (w_hs) begin
               w_hdr_acc = 1'b1;
               if (r_hdr_cnt == 3'd7) begin
                  if (w_hdr_bad) begin
                     w_state_nxt = S_ERR;
                     w_code_nxt  = CODE_HDR;
                  end else begin
                     w_state_nxt = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (w_hs) begin
               w_dat_acc = 1'b1;
               if (r_byte_cnt == 2'd3) w_state_nxt = S_WR;
            end
         end
         S_WR, S_RD: begin
            if (!r_req) begin
               w_issue = 1'b1;
            end else if (ext_ack_i) begin
               if (ext_error_i) begin
                  w_state_nxt = S_ERR;
                  w_code_nxt  = CODE_BUS;
               end else begin
                  w_ack_ok = 1'b1;
                  if (r_state == S_WR) w_state_nxt = w_last ? S_RD : S_DATA;
                  else if (w_last)     w_state_nxt = S_CHECK;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = S_ERR;
               w_code_nxt  = CODE_TMO;
            end
         end
         S_CHECK: begin
            if (r_rsum == r_csum) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_ERR;
               w_code_nxt  = CODE_CSUM;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath: byte assembly, checksums, bus request handshake and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_ready  <= 1'b0;
         r_hdr_cnt  <= '0;
         r_hdr      <= '0;
         r_byte_cnt <= '0;
         r_base     <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_words    <= '0;
         r_word_cnt <= '0;
         r_csum     <= '0;
         r_rsum     <= '0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_tmo      <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= '0;
         r_rst_soft <= 1'b0;
      end else begin
         r_s_ready <= (w_state_nxt == S_HDR) | (w_state_nxt == S_DATA);

         if (w_start) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_word_cnt <= '0;
            r_rst_soft <= 1'b0;
            r_hdr_cnt  <= '0;
            r_byte_cnt <= '0;
         end

         if (w_hdr_acc) begin
            r_hdr     <= w_hdr[63:8];
            r_hdr_cnt <= r_hdr_cnt + 1'b1;
            if (r_hdr_cnt == 3'd7) begin
               r_base  <= w_hdr[31:0];
               r_addr  <= w_hdr[31:0];
               r_words <= w_hdr[CNT_W+33:34];
               r_csum  <= '0;
            end
         end

         if (w_dat_acc) begin
            r_wdata    <= w_word;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd3) r_csum <= r_csum ^ w_word;
         end

         // Request is dropped on any ack or on timeout, giving at least one idle cycle between requests.
         if (w_issue) begin
            r_req <= 1'b1;
            r_we  <= (r_state == S_WR);
            r_tmo <= '0;
         end else if (r_req) begin
            if (ext_ack_i || w_tmo_hit) r_req <= 1'b0;
            else                        r_tmo <= r_tmo + 1'b1;
         end

         if (w_ack_ok) begin
            if (r_state == S_RD) r_rsum <= r_rsum ^ ext_rdata_i;
            if ((r_state == S_WR) && w_last) begin
               r_addr     <= r_base;
               r_word_cnt <= '0;
               r_rsum     <= '0;
            end else begin
               r_addr     <= r_addr + 32'd4;
               r_word_cnt <= w_cnt_inc;
            end
         end

         if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
            r_err      <= 1'b1;
            r_err_code <= w_code_nxt;
         end

         if ((r_state == S_CHECK) && (w_state_nxt == S_RUN)) begin
            r_done     <= 1'b1;
            r_rst_soft <= 1'b1;
         end
      end
   end

   assign s_ready_o   = r_s_ready;
   assign ext_req_o   = r_req;
   assign ext_we_o    = r_we;
   assign ext_addr_o  = r_addr;
   assign ext_wdata_o = r_wdata;
   assign rst_soft_no = r_rst_soft;
   assign busy_o      = (r_state == S_HDR) | (r_state == S_DATA) | (r_state == S_WR)
                      | (r_state == S_RD)  | (r_state == S_CHECK);
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign err_code_o  = r_err_code;
   assign word_cnt_o  = r_word_cnt;

endmodule

// File: tb/tb_sophon_ext_loader.sv
// Bench for sophon_ext_loader: table of load sessions against a behavioural ext-port slave.
// Expected bus writes are queued as payload bytes are driven and compared when the slave sees each write ack.
// Hand sequences cover reset values and a reset pulse during the read-back pass.
module tb_sophon_ext_loader;

   localparam int CNT_W = 16;
   localparam int TMO   = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_i;
   logic             s_valid_i;
   logic [7:0]       s_data_i;
   logic             s_ready_o;
   logic             ext_req_o;
   logic             ext_we_o;
   logic [31:0]      ext_addr_o;
   logic [31:0]      ext_wdata_o;
   logic             ext_ack_i;
   logic             ext_error_i;
   logic [31:0]      ext_rdata_i;
   logic             rst_soft_no;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic [2:0]       err_code_o;
   logic [CNT_W-1:0] word_cnt_o;

   sophon_ext_loader #(.TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
      .ext_req_o(ext_req_o), .ext_we_o(ext_we_o), .ext_addr_o(ext_addr_o), .ext_wdata_o(ext_wdata_o),
      .ext_ack_i(ext_ack_i), .ext_error_i(ext_error_i), .ext_rdata_i(ext_rdata_i),
      .rst_soft_no(rst_soft_no), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .err_code_o(err_code_o), .word_cnt_o(word_cnt_o)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] base;
      logic [31:0] len;
      logic [7:0]  seed;
      int          gap_max;
      int          ack_dly;      // 0 = slave never acks
      int          err_wr;       // 1-based write that gets ext_error_i, 0 = none
      bit          corrupt;      // first read returns 0xDEADBEEF
      bit          exp_done;
      bit          exp_err;
      logic [2:0]  exp_code;
      logic [15:0] exp_cnt;
      int          exp_req_cyc;  // -1 = not checked
   } vec_t;

   vec_t vecs [12];

   // Slave configuration and observations.
   int          cfg_dly     = 2;
   int          cfg_err_wr  = 0;
   bit          cfg_corrupt = 1'b0;
   int          wr_idx      = 0;
   int          rd_idx      = 0;
   int          req_cyc     = 0;
   int          last_rd_cyc = 0;
   logic [31:0] mem [logic [31:0]];
   logic [63:0] exp_wr [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Behavioural ext-port slave, driven on the falling edge.
   initial begin
      int          wcnt;
      logic [63:0] e;
      wcnt        = 0;
      ext_ack_i   = 1'b0;
      ext_error_i = 1'b0;
      ext_rdata_i = '0;
      forever begin
         @(negedge clk);
         ext_ack_i   = 1'b0;
         ext_error_i = 1'b0;
         if (!rst_n) begin
            wcnt = 0;
         end else if (ext_req_o) begin
            req_cyc++;
            wcnt++;
            if (cfg_dly != 0 && wcnt == cfg_dly) begin
               wcnt      = 0;
               ext_ack_i = 1'b1;
               if (ext_we_o) begin
                  wr_idx++;
                  if (wr_idx == cfg_err_wr) begin
                     ext_error_i = 1'b1;
                  end else begin
                     mem[ext_addr_o] = ext_wdata_o;
                     if (exp_wr.size() == 0) begin
                        check("unexpected write", ext_addr_o, 32'hFFFF_FFFF);
                     end else begin
                        e = exp_wr.pop_front();
                        check("write addr", ext_addr_o, e[63:32]);
                        check("write data", ext_wdata_o, e[31:0]);
                     end
                  end
               end else begin
                  rd_idx++;
                  last_rd_cyc = cyc;
                  if (cfg_corrupt && rd_idx == 1)   ext_rdata_i = 32'hDEAD_BEEF;
                  else if (mem.exists(ext_addr_o))  ext_rdata_i = mem[ext_addr_o];
                  else                              ext_rdata_i = 32'h0;
               end
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Called on a falling edge; returns on a falling edge. ok=0 if the byte was never accepted.
   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      ok        = 1'b0;
      s_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
      s_data_i  = b;
      s_valid_i = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (s_ready_o) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         if (err_o) break;
         @(negedge clk);
      end
      s_valid_i = 1'b0;
   endtask

   function automatic int gap_of(input int m);
      return (m == 0) ? 0 : int'($urandom_range(0, m));
   endfunction

   // Start a session and stream header plus payload, queueing the expected writes.
   task automatic send_image(input vec_t v);
      logic [63:0] hdr;
      logic [7:0]  b;
      logic [31:0] w;
      bit          ok;
      exp_wr.delete();
      cfg_dly     = v.ack_dly;
      cfg_err_wr  = v.err_wr;
      cfg_corrupt = v.corrupt;
      wr_idx      = 0;
      rd_idx      = 0;
      req_cyc     = 0;
      w           = '0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      hdr = {v.len, v.base};
      ok  = 1'b1;
      for (int i = 0; i < 8 && ok; i++) send_byte(hdr[8*i +: 8], gap_of(v.gap_max), ok);
      for (int i = 0; ok && i < int'(v.len); i++) begin
         b = v.seed + 8'(8'h11 * (i + 1));
         w = {b, w[31:8]};
         if (i % 4 == 3) exp_wr.push_back({v.base + 32'(i - 3), w});
         send_byte(b, gap_of(v.gap_max), ok);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int t;
      int done_cyc;
      send_image(v);
      t = 0;
      while (!(done_o || err_o) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      done_cyc = cyc;
      check({tag, " session ended"}, 32'(done_o | err_o), 32'd1);
      check({tag, " done_o"},      32'(done_o),      32'(v.exp_done));
      check({tag, " err_o"},       32'(err_o),       32'(v.exp_err));
      check({tag, " err_code_o"},  32'(err_code_o),  32'(v.exp_code));
      check({tag, " word_cnt_o"},  32'(word_cnt_o),  32'(v.exp_cnt));
      check({tag, " rst_soft_no"}, 32'(rst_soft_no), 32'(v.exp_done));
      check({tag, " busy_o"},      32'(busy_o),      32'd0);
      check({tag, " ext_req_o"},   32'(ext_req_o),   32'd0);
      if (v.exp_done) begin
         check({tag, " done after last read ack"}, 32'(done_cyc - last_rd_cyc), 32'd2);
         check({tag, " writes outstanding"}, 32'(exp_wr.size()), 32'd0);
      end
      if (v.exp_req_cyc >= 0) check({tag, " req cycles"}, 32'(req_cyc), 32'(v.exp_req_cyc));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " s_ready_o"},   32'(s_ready_o),   32'd0);
      check({tag, " ext_req_o"},   32'(ext_req_o),   32'd0);
      check({tag, " ext_we_o"},    32'(ext_we_o),    32'd0);
      check({tag, " ext_addr_o"},  ext_addr_o,       32'd0);
      check({tag, " ext_wdata_o"}, ext_wdata_o,      32'd0);
      check({tag, " rst_soft_no"}, 32'(rst_soft_no), 32'd0);
      check({tag, " busy_o"},      32'(busy_o),      32'd0);
      check({tag, " done_o"},      32'(done_o),      32'd0);
      check({tag, " err_o"},       32'(err_o),       32'd0);
      check({tag, " err_code_o"},  32'(err_code_o),  32'd0);
      check({tag, " word_cnt_o"},  32'(word_cnt_o),  32'd0);
   endtask

   initial begin
      int t;
      //          base          len            seed  gap dly err cor done err code cnt   reqcyc
      vecs[0]  = '{32'h8000_0000, 32'd8,         8'h00, 0, 2, 0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd2, 8};
      vecs[1]  = '{32'h8000_0002, 32'd8,         8'h00, 0, 2, 0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0, 0};
      vecs[2]  = '{32'h8000_0000, 32'd6,         8'h00, 0, 2, 0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0, 0};
      vecs[3]  = '{32'h8000_0000, 32'd0,         8'h00, 0, 2, 0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0, 0};
      vecs[4]  = '{32'h8000_0000, 32'h0004_0000, 8'h00, 0, 2, 0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0, 0};
      vecs[5]  = '{32'h8000_0000, 32'd12,        8'h03, 0, 2, 2, 1'b0, 1'b0, 1'b1, 3'd2, 16'd1, -1};
      vecs[6]  = '{32'h8000_0100, 32'd8,         8'h01, 0, 0, 0, 1'b0, 1'b0, 1'b1, 3'd3, 16'd0, 8};
      vecs[7]  = '{32'h8000_0100, 32'd8,         8'h02, 0, 8, 0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd2, 32};
      vecs[8]  = '{32'h8000_0000, 32'd8,         8'h00, 0, 1, 0, 1'b1, 1'b0, 1'b1, 3'd4, 16'd2, -1};
      vecs[9]  = '{32'h8000_1000, 32'd16,        8'h05, 0, 3, 0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd4, -1};
      vecs[10] = '{32'h8000_0000, 32'd8,         8'h00, 3, 2, 0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd2, 8};
      vecs[11] = '{32'hFFFF_FFF8, 32'd16,        8'h07, 1, 1, 0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd4, -1};

      rst_n     = 1'b0;
      start_i   = 1'b0;
      s_valid_i = 1'b0;
      s_data_i  = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset pulse while the read-back pass has a request outstanding.
      begin
         vec_t v;
         v = vecs[0];
         v.ack_dly = 6;
         send_image(v);
         t = 0;
         while (!(ext_req_o && !ext_we_o) && t < 500) begin
            @(negedge clk);
            t++;
         end
         check("midrst read outstanding", 32'(ext_req_o & ~ext_we_o), 32'd1);
         #2 rst_n = 1'b0;
         #1 check_reset_vals("midrst");
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         repeat (2) @(negedge clk);
         run_vec(vecs[0], "after_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
